// File: rtl/traffic_light_monitor.sv
// Watches the red/green/yellow lamp lines of the traffic-light controller on the shared clock.
// It flags one-hot, sequence and dwell violations and counts completed light cycles.
module traffic_light_monitor #(
  parameter int RED_CYCLES    = 10,
  parameter int GREEN_CYCLES  = 10,
  parameter int YELLOW_CYCLES = 3,
  parameter int DW_W          = 5,
  parameter int CYC_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             red,
  input  logic             green,
  input  logic             yellow,
  input  logic             clr_err,
  output logic [1:0]       lamp_state,
  output logic             locked,
  output logic             err_onehot,
  output logic             err_seq,
  output logic             err_dwell,
  output logic             fault,
  output logic             err_event,
  output logic [CYC_W-1:0] cycle_count
);

  localparam logic [1:0] CODE_R   = 2'b00;
  localparam logic [1:0] CODE_G   = 2'b01;
  localparam logic [1:0] CODE_Y   = 2'b10;
  localparam logic [1:0] CODE_INV = 2'b11;

  localparam logic [DW_W-1:0] EXP_R   = DW_W'(RED_CYCLES);
  localparam logic [DW_W-1:0] EXP_G   = DW_W'(GREEN_CYCLES);
  localparam logic [DW_W-1:0] EXP_Y   = DW_W'(YELLOW_CYCLES);
  localparam logic [DW_W-1:0] DW_MAX  = {DW_W{1'b1}};

  typedef enum logic [1:0] {UNSYNC, TRK_R, TRK_G, TRK_Y} state_t;

  state_t           state_q, state_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [1:0]       lamp_q, code_d;
  logic             locked_q;
  logic             oh_q, oh_d;
  logic             seq_q, seq_d;
  logic             dw_q, dw_d;
  logic             fault_q;
  logic             event_q;
  logic             v_oh, v_seq, v_dw;
  logic [1:0]       trk_code;
  logic [DW_W-1:0]  exp_dwell;

  function automatic logic [1:0] nxt_code(input logic [1:0] c);
    return (c == CODE_Y) ? CODE_R : c + 2'd1;
  endfunction

  function automatic state_t trk_state(input logic [1:0] c);
    case (c)
      CODE_R:  return TRK_R;
      CODE_G:  return TRK_G;
      default: return TRK_Y;
    endcase
  endfunction

  always_comb begin
    code_d = CODE_INV;
    case ({red, green, yellow})
      3'b100:  code_d = CODE_R;
      3'b010:  code_d = CODE_G;
      3'b001:  code_d = CODE_Y;
      default: code_d = CODE_INV;
    endcase
  end

  always_comb begin
    trk_code  = CODE_INV;
    exp_dwell = '0;
    case (state_q)
      TRK_R:   begin trk_code = CODE_R; exp_dwell = EXP_R; end
      TRK_G:   begin trk_code = CODE_G; exp_dwell = EXP_G; end
      TRK_Y:   begin trk_code = CODE_Y; exp_dwell = EXP_Y; end
      default: begin trk_code = CODE_INV; exp_dwell = '0; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    cyc_d   = cyc_q;
    v_oh    = 1'b0;
    v_seq   = 1'b0;
    v_dw    = 1'b0;
    if (!en) begin
      state_d = UNSYNC;
      dwell_d = '0;
    end else if (state_q == UNSYNC) begin
      // lamp_q holds the previous sample's code; lock only on a legal valid->valid step
      if (code_d == CODE_INV) begin
        v_oh = 1'b1;
      end else if (lamp_q != CODE_INV && code_d == nxt_code(lamp_q)) begin
        state_d = trk_state(code_d);
        dwell_d = DW_W'(1);
      end
    end else begin
      if (code_d == trk_code) begin
        if (dwell_q == exp_dwell) v_dw = 1'b1;
        if (dwell_q != DW_MAX) dwell_d = dwell_q + DW_W'(1);
      end else if (code_d == nxt_code(trk_code)) begin
        if (dwell_q != exp_dwell) v_dw = 1'b1;
        state_d = trk_state(code_d);
        dwell_d = DW_W'(1);
        if (trk_code == CODE_Y) cyc_d = cyc_q + CYC_W'(1);
      end else if (code_d == CODE_INV) begin
        v_oh    = 1'b1;
        state_d = UNSYNC;
        dwell_d = '0;
      end else begin
        v_seq   = 1'b1;
        state_d = UNSYNC;
        dwell_d = '0;
      end
    end
  end

  // A violation in the same clock as clr_err keeps its flag set.
  assign oh_d  = (oh_q  & ~clr_err) | v_oh;
  assign seq_d = (seq_q & ~clr_err) | v_seq;
  assign dw_d  = (dw_q  & ~clr_err) | v_dw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= UNSYNC;
      dwell_q  <= '0;
      cyc_q    <= '0;
      lamp_q   <= CODE_INV;
      locked_q <= 1'b0;
      oh_q     <= 1'b0;
      seq_q    <= 1'b0;
      dw_q     <= 1'b0;
      fault_q  <= 1'b0;
      event_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      cyc_q    <= cyc_d;
      lamp_q   <= code_d;
      locked_q <= (state_d != UNSYNC);
      oh_q     <= oh_d;
      seq_q    <= seq_d;
      dw_q     <= dw_d;
      fault_q  <= oh_d | seq_d | dw_d;
      event_q  <= v_oh | v_seq | v_dw;
    end
  end

  assign lamp_state  = lamp_q;
  assign locked      = locked_q;
  assign err_onehot  = oh_q;
  assign err_seq     = seq_q;
  assign err_dwell   = dw_q;
  assign fault       = fault_q;
  assign err_event   = event_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: vector table, directed lamp sequences, and a randomized
// lamp stream compared each clock against a run-length reference model.
module tb_traffic_light_monitor;

  logic        clk = 1'b0;
  logic        rst, en, red, green, yellow, clr_err;
  logic [1:0]  lamp_state;
  logic        locked, err_onehot, err_seq, err_dwell, fault, err_event;
  logic [15:0] cycle_count;

  int checks   = 0;
  int failures = 0;
  int ev_total = 0;

  // reference model state: phase -1 = not synchronised, 0/1/2 = R/G/Y
  int m_phase, m_run, m_prev, m_cycles;
  bit m_oh, m_seq, m_dw, m_fault, m_event, m_locked;

  localparam logic [2:0] R = 3'b100, G = 3'b010, Y = 3'b001;

  typedef struct packed {
    logic       e;
    logic [2:0] rgy;
    logic       c;
    logic [7:0] exp_vec;
  } vec_t;
  vec_t tbl [12];

  traffic_light_monitor dut (
    .clk(clk), .rst(rst), .en(en), .red(red), .green(green), .yellow(yellow),
    .clr_err(clr_err), .lamp_state(lamp_state), .locked(locked), .err_onehot(err_onehot),
    .err_seq(err_seq), .err_dwell(err_dwell), .fault(fault), .err_event(err_event),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  function automatic int exp_of(input int p);
    return (p == 2) ? 3 : 10;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = -1; m_run = 0; m_prev = 3; m_cycles = 0;
    m_oh = 0; m_seq = 0; m_dw = 0; m_fault = 0; m_event = 0; m_locked = 0;
  endtask

  task automatic model_step(input logic e, input logic [2:0] p, input logic c);
    int code;
    bit oh, sq, dw;
    oh = 0; sq = 0; dw = 0;
    if (int'(p[2]) + int'(p[1]) + int'(p[0]) != 1) code = 3;
    else code = p[2] ? 0 : (p[1] ? 1 : 2);
    if (!e) begin
      m_phase = -1; m_run = 0;
    end else if (m_phase < 0) begin
      if (code == 3) oh = 1;
      else if (m_prev != 3 && code == (m_prev + 1) % 3) begin
        m_phase = code; m_run = 1;
      end
    end else if (code == m_phase) begin
      if (m_run == exp_of(m_phase)) dw = 1;
      if (m_run < 31) m_run++;
    end else if (code == (m_phase + 1) % 3) begin
      if (m_run != exp_of(m_phase)) dw = 1;
      if (m_phase == 2) m_cycles = (m_cycles + 1) % 65536;
      m_phase = code; m_run = 1;
    end else if (code == 3) begin
      oh = 1; m_phase = -1; m_run = 0;
    end else begin
      sq = 1; m_phase = -1; m_run = 0;
    end
    m_oh  = (m_oh  && !c) || oh;
    m_seq = (m_seq && !c) || sq;
    m_dw  = (m_dw  && !c) || dw;
    m_fault  = m_oh || m_seq || m_dw;
    m_event  = oh || sq || dw;
    m_locked = (m_phase >= 0);
    m_prev   = code;
  endtask

  function automatic logic [7:0] dut_vec();
    return {lamp_state, locked, err_onehot, err_seq, err_dwell, fault, err_event};
  endfunction

  task automatic tick(input logic e, input logic [2:0] p, input logic c);
    logic [7:0] mv;
    en = e; {red, green, yellow} = p; clr_err = c;
    @(posedge clk); #1;
    model_step(e, p, c);
    mv = {2'(m_prev), m_locked, m_oh, m_seq, m_dw, m_fault, m_event};
    chk("model_vec", int'(dut_vec()), int'(mv));
    chk("model_cycles", int'(cycle_count), m_cycles);
    ev_total += int'(err_event);
  endtask

  task automatic run(input logic [2:0] p, input int n);
    for (int i = 0; i < n; i++) tick(1'b1, p, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr_err = 1'b0; {red, green, yellow} = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  int cur, rem, rr;
  logic [2:0] pat, inv_pats [5];

  initial begin
    rst = 1'b1; en = 1'b0; red = 1'b0; green = 1'b0; yellow = 1'b0; clr_err = 1'b0;
    @(posedge clk); #1;
    chk("reset_lamp", int'(lamp_state), 3);
    chk("reset_outs", int'({locked, err_onehot, err_seq, err_dwell, fault, err_event}), 0);
    chk("reset_cycles", int'(cycle_count), 0);
    do_reset();

    // T5 plus order/enable corners: {en, rgy, clr, {lamp,locked,oh,seq,dw,fault,event}}
    tbl[0]  = '{1'b1, 3'b110, 1'b0, 8'b11_0_1_0_0_1_1};
    tbl[1]  = '{1'b1, R,      1'b1, 8'b00_0_0_0_0_0_0};
    tbl[2]  = '{1'b1, 3'b000, 1'b1, 8'b11_0_1_0_0_1_1};
    tbl[3]  = '{1'b1, R,      1'b0, 8'b00_0_1_0_0_1_0};
    tbl[4]  = '{1'b1, G,      1'b0, 8'b01_1_1_0_0_1_0};
    tbl[5]  = '{1'b1, R,      1'b0, 8'b00_0_1_1_0_1_1};
    tbl[6]  = '{1'b1, Y,      1'b0, 8'b10_0_1_1_0_1_0};
    tbl[7]  = '{1'b1, R,      1'b0, 8'b00_1_1_1_0_1_0};
    tbl[8]  = '{1'b0, 3'b111, 1'b0, 8'b11_0_1_1_0_1_0};
    tbl[9]  = '{1'b0, G,      1'b0, 8'b01_0_1_1_0_1_0};
    tbl[10] = '{1'b1, Y,      1'b1, 8'b10_1_0_0_0_0_0};
    tbl[11] = '{1'b1, Y,      1'b0, 8'b10_1_0_0_0_0_0};
    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].e, tbl[i].rgy, tbl[i].c);
      chk($sformatf("table_row%0d", i), int'(dut_vec()), int'(tbl[i].exp_vec));
    end

    // T1 legal run from mid-red
    do_reset();
    ev_total = 0;
    run(R, 5);
    tick(1'b1, G, 1'b0);
    chk("t1_lock", int'(locked), 1);
    run(G, 9); run(Y, 3); run(R, 10);
    for (int k = 0; k < 2; k++) begin
      run(G, 10); run(Y, 3); run(R, 10);
    end
    chk("t1_cycles", int'(cycle_count), 3);
    chk("t1_fault", int'(fault), 0);
    chk("t1_events", ev_total, 0);

    // T2 overrun, then long hold to exercise dwell saturation
    ev_total = 0;
    run(G, 10);
    chk("t2_pre_dwell", int'(err_dwell), 0);
    tick(1'b1, G, 1'b0);
    chk("t2_dwell", int'(err_dwell), 1);
    chk("t2_event", int'(err_event), 1);
    chk("t2_locked", int'(locked), 1);
    run(G, 34);
    chk("t2_single_event", ev_total, 1);

    // T3 underrun Y2 then R
    run(Y, 2);
    tick(1'b1, R, 1'b0);
    chk("t3_event", int'(err_event), 1);
    chk("t3_locked", int'(locked), 1);
    ev_total = 0;
    run(R, 9); run(G, 10); run(Y, 3); run(R, 1);
    chk("t3_clean_period", ev_total, 0);

    // T4 R then Y
    tick(1'b1, Y, 1'b0);
    chk("t4_seq", int'(err_seq), 1);
    chk("t4_unlocked", int'(locked), 0);
    ev_total = 0;
    tick(1'b1, R, 1'b0);
    chk("t4_relock", int'(locked), 1);
    chk("t4_no_event", ev_total, 0);

    // T6 enable low with illegal patterns, then async reset mid-green
    tick(1'b1, R, 1'b1);
    chk("t6_cleared", int'(fault), 0);
    chk("t6_cycles", int'(cycle_count), 5);
    ev_total = 0;
    for (int k = 0; k < 8; k++) tick(1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    chk("t6_en_events", ev_total, 0);
    chk("t6_en_flags", int'({locked, err_onehot, err_seq, err_dwell, fault}), 0);
    chk("t6_en_cycles", int'(cycle_count), 5);
    run(R, 1); run(G, 4);
    chk("t6_locked_g", int'(locked), 1);
    #3 rst = 1'b1;
    #1;
    chk("t6_async_lamp", int'(lamp_state), 3);
    chk("t6_async_outs", int'({locked, err_onehot, err_seq, err_dwell, fault, err_event}), 0);
    chk("t6_async_cycles", int'(cycle_count), 0);
    @(posedge clk); #1;
    chk("t6_held_lamp", int'(lamp_state), 3);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // randomized lamp stream against the model
    inv_pats[0] = 3'b000; inv_pats[1] = 3'b011; inv_pats[2] = 3'b101;
    inv_pats[3] = 3'b110; inv_pats[4] = 3'b111;
    cur = 0; rem = 4;
    for (int t = 0; t < 2500; t++) begin
      rr = $urandom_range(0, 99);
      if (rr < 2) pat = inv_pats[$urandom_range(0, 4)];
      else if (rr < 4) pat = 3'b100 >> ((cur + 2) % 3);
      else begin
        pat = 3'b100 >> cur;
        rem--;
        if (rem <= 0) begin
          cur = (cur + 1) % 3;
          rem = exp_of(cur);
          if ($urandom_range(0, 7) == 0) rem = rem + ($urandom_range(0, 1) ? 1 : -1);
        end
      end
      tick(1'($urandom_range(0, 99) != 0), pat, 1'($urandom_range(0, 29) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
